// File: rtl/morph_filter_nxn.sv
// Binary KxK morphology stage (erosion / dilation / bypass) for the
// frame-difference motion path. The window is bottom-right aligned on the
// current pixel. Out-of-frame window positions take the neutral value of
// the active operation. Latency is fixed at 3 clocks for pixels and framing.
module morph_filter_nxn #(
   parameter int IMG_HDISP = 640,
   parameter int IMG_VDISP = 480,
   parameter int KSIZE     = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] mode,
   input  logic       per_frame_vsync,
   input  logic       per_frame_href,
   input  logic       per_frame_clken,
   input  logic       per_img_Bit,
   output logic       post_frame_vsync,
   output logic       post_frame_href,
   output logic       post_frame_clken,
   output logic       post_img_Bit
);
   localparam int CW  = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
   localparam int RW  = (IMG_VDISP > 1) ? $clog2(IMG_VDISP) : 1;
   localparam int KM1 = KSIZE - 1;
   localparam logic [CW-1:0] COL_MAX = CW'(IMG_HDISP - 1);
   localparam logic [RW-1:0] ROW_MAX = RW'(IMG_VDISP - 1);

   typedef enum logic [1:0] {
      MODE_ERODE  = 2'b00,
      MODE_DILATE = 2'b01,
      MODE_BYPASS = 2'b10
   } mode_e;

   generate
      if (KSIZE != 3 && KSIZE != 5) begin : g_bad_ksize
         $error("morph_filter_nxn: KSIZE must be 3 or 5");
      end
   endgenerate

   // Framing delay lines; stage 0 doubles as the previous-cycle value for edge detection.
   logic [2:0]                  vs_q, hr_q, ce_q;
   logic [1:0]                  bit_q;
   logic [CW-1:0]               col_q, col_d;
   logic [RW-1:0]               row_q, row_d;
   mode_e                       active_mode_q, active_mode_d;
   logic                        frame_ok_q, frame_ok_d;
   // win_q[j] holds window row j (0 = current line); bit k is column age k (0 = current pixel).
   logic [KSIZE-1:0][KSIZE-1:0] win_q, win_d;
   logic [KSIZE-1:0]            rowred_q, rowred_d;
   logic                        out_q, out_d;
   logic                        red3;

   // Per-column vertical history of the previous KSIZE-1 lines; bit 0 is the line above.
   logic [KM1-1:0]              lb_q [IMG_HDISP];
   logic [KM1-1:0]              lb_rd;
   logic [KSIZE-1:0]            col_new;

   logic vs_rise, href_fall, pix_en, is_dil, is_byp, neutral;

   assign vs_rise   = per_frame_vsync & ~vs_q[0];
   assign href_fall = ~per_frame_href & hr_q[0];
   assign pix_en    = per_frame_href & per_frame_clken;
   assign is_dil    = (active_mode_q == MODE_DILATE);
   assign is_byp    = (active_mode_q == MODE_BYPASS);
   assign neutral   = ~is_dil;
   assign lb_rd     = lb_q[col_q];

   // Position counters, per-frame mode latch and first-frame qualifier.
   always_comb begin
      col_d         = col_q;
      row_d         = row_q;
      active_mode_d = active_mode_q;
      frame_ok_d    = frame_ok_q;
      if (href_fall) begin
         col_d = '0;
      end else if (pix_en && col_q != COL_MAX) begin
         col_d = col_q + 1'b1;
      end
      // A vsync rise beats a coincident href fall: the row restarts.
      if (vs_rise) begin
         row_d         = '0;
         active_mode_d = mode[1] ? MODE_BYPASS : mode_e'(mode);
         frame_ok_d    = 1'b1;
      end else if (href_fall && row_q != ROW_MAX) begin
         row_d = row_q + 1'b1;
      end
   end

   // Stage 1: build the incoming window column with row padding, then shift the window.
   always_comb begin
      col_new    = {KSIZE{neutral}};
      col_new[0] = per_img_Bit;
      for (int j = 1; j < KSIZE; j++) begin
         if (int'(row_q) >= j) col_new[j] = lb_rd[j-1];
      end
      win_d = win_q;
      if (pix_en) begin
         for (int j = 0; j < KSIZE; j++) begin
            // First pixel of a line: older columns lie left of the frame.
            if (col_q == '0) win_d[j] = {{KM1{neutral}}, col_new[j]};
            else             win_d[j] = {win_q[j][KSIZE-2:0], col_new[j]};
         end
      end
   end

   // Stages 2 and 3: per-row reduction, then cross-row reduction and output gating.
   always_comb begin
      for (int j = 0; j < KSIZE; j++) begin
         rowred_d[j] = is_dil ? (|win_q[j]) : (&win_q[j]);
      end
      red3  = is_dil ? (|rowred_q) : (&rowred_q);
      out_d = frame_ok_q & hr_q[1] & (is_byp ? bit_q[1] : red3);
   end

   // Pipeline, counter and control registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vs_q          <= '0;
         hr_q          <= '0;
         ce_q          <= '0;
         bit_q         <= '0;
         col_q         <= '0;
         row_q         <= '0;
         active_mode_q <= MODE_ERODE;
         frame_ok_q    <= 1'b0;
         win_q         <= '0;
         rowred_q      <= '0;
         out_q         <= 1'b0;
      end else begin
         vs_q          <= {vs_q[1:0], per_frame_vsync};
         hr_q          <= {hr_q[1:0], per_frame_href};
         ce_q          <= {ce_q[1:0], per_frame_clken};
         bit_q         <= {bit_q[0], per_img_Bit};
         col_q         <= col_d;
         row_q         <= row_d;
         active_mode_q <= active_mode_d;
         frame_ok_q    <= frame_ok_d;
         win_q         <= win_d;
         rowred_q      <= rowred_d;
         out_q         <= out_d;
      end
   end

   // Line-buffer write; stale contents are masked by row padding, so no clear is needed.
   always_ff @(posedge clk) begin
      if (rst_n && pix_en) begin
         lb_q[col_q] <= {lb_rd[KM1-2:0], per_img_Bit};
      end
   end

   assign post_frame_vsync = vs_q[2];
   assign post_frame_href  = hr_q[2];
   assign post_frame_clken = ce_q[2];
   assign post_img_Bit     = out_q;

endmodule

// File: tb/tb_morph_filter_nxn.sv
// Bench for morph_filter_nxn: K=3 and K=5 instances share one stimulus stream.
// The driver records per-cycle expectations, and a negedge checker compares
// the outputs three clocks later.
module tb_morph_filter_nxn;
   localparam int W    = 8;
   localparam int H    = 6;
   localparam int NEXP = 8192;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] mode;
   logic       vs_i, hr_i, ce_i, bit_i;
   logic       vs3, hr3, ce3, b3;
   logic       vs5, hr5, ce5, b5;

   always #5 clk = ~clk;

   morph_filter_nxn #(.IMG_HDISP(W), .IMG_VDISP(H), .KSIZE(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .mode(mode),
      .per_frame_vsync(vs_i), .per_frame_href(hr_i), .per_frame_clken(ce_i), .per_img_Bit(bit_i),
      .post_frame_vsync(vs3), .post_frame_href(hr3), .post_frame_clken(ce3), .post_img_Bit(b3));

   morph_filter_nxn #(.IMG_HDISP(W), .IMG_VDISP(H), .KSIZE(5)) dut5 (
      .clk(clk), .rst_n(rst_n), .mode(mode),
      .per_frame_vsync(vs_i), .per_frame_href(hr_i), .per_frame_clken(ce_i), .per_img_Bit(bit_i),
      .post_frame_vsync(vs5), .post_frame_href(hr5), .post_frame_clken(ce5), .post_img_Bit(b5));

   typedef struct {
      logic vs, hr, ce, chk, e3, e5;
      bit   v;
   } exp_t;

   typedef struct {
      logic [1:0] m;
      int         gap;
      int         px, py;
      logic       pv;
      int         x0, x1, y0, y1;   // K=3 region holding pv
      int         u0, u1, v0, v1;   // K=5 region holding pv
   } vec_t;

   exp_t exp_tab [NEXP];
   logic img  [H][W];
   logic exp3 [H][W];
   logic exp5 [H][W];

   int   ecount  = 0;
   int   tests   = 0;
   int   fails   = 0;
   int   rst_cnt = 0;
   logic rst_smp = 1'b1;
   logic ok_m    = 1'b0;
   logic vs_prev = 1'b0;

   always @(posedge clk) begin
      ecount  <= ecount + 1;
      rst_smp <= rst_n;
   end

   task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         if (fails <= 40)
            $display("FAIL %s @edge %0d: got %b, expected %b", name, ecount, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (rst_smp === 1'b0) begin
         check("reset_out_k3", {vs3, hr3, ce3, b3}, 4'b0000);
         check("reset_out_k5", {vs5, hr5, ce5, b5}, 4'b0000);
      end else if (ecount >= 3 && ecount - 3 < NEXP && exp_tab[ecount-3].v) begin
         check("sync_k3", {1'b0, vs3, hr3, ce3},
               {1'b0, exp_tab[ecount-3].vs, exp_tab[ecount-3].hr, exp_tab[ecount-3].ce});
         check("sync_k5", {1'b0, vs5, hr5, ce5},
               {1'b0, exp_tab[ecount-3].vs, exp_tab[ecount-3].hr, exp_tab[ecount-3].ce});
         if (exp_tab[ecount-3].chk) begin
            check("pixel_k3", {3'b000, b3}, {3'b000, exp_tab[ecount-3].e3});
            check("pixel_k5", {3'b000, b5}, {3'b000, exp_tab[ecount-3].e5});
         end
      end
   end

   // One input cycle: drive inputs just after the edge and record what must appear 3 clocks later.
   task automatic step(input logic vs, input logic hr, input logic ce, input logic b,
                       input logic chk, input logic e3, input logic e5);
      @(posedge clk);
      #1;
      rst_n = (rst_cnt == 0);
      if (rst_cnt > 0) rst_cnt--;
      vs_i  = vs;
      hr_i  = hr;
      ce_i  = ce;
      bit_i = b;
      if (!rst_n) begin
         ok_m    = 1'b0;
         vs_prev = 1'b0;
         for (int d = 0; d < 3; d++)
            if (ecount - d >= 0 && ecount - d < NEXP) exp_tab[ecount-d].v = 1'b0;
      end else begin
         if (vs && !vs_prev) ok_m = 1'b1;
         vs_prev = vs;
      end
      if (ecount < NEXP)
         exp_tab[ecount] = '{vs, hr, ce, chk, ok_m & e3, ok_m & e5, rst_n};
   endtask

   task automatic drive_frame(input logic [1:0] m0, input int gap, input int sw_row,
                              input logic [1:0] m1, input int rst_row, input int rst_len);
      logic byp;
      logic b;
      logic ce;
      byp  = m0[1];
      mode = m0;
      repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int r = 0; r < H; r++) begin
         if (r == sw_row) mode = m1;
         for (int c = 0; c < W; c++) begin
            for (int g = 0; g <= gap; g++) begin
               if (r == rst_row && c == 4 && g == 0) rst_cnt = rst_len;
               if (g == 0) begin
                  step(1'b0, 1'b1, 1'b1, img[r][c], 1'b1, exp3[r][c], exp5[r][c]);
               end else begin
                  b = 1'($urandom);
                  step(1'b0, 1'b1, 1'b0, b, byp, b, b);
               end
            end
         end
         // Blanking: stray clken without href must be ignored by the filter.
         for (int g = 0; g < 4; g++) begin
            ce = 1'($urandom);
            b  = 1'($urandom);
            step(1'b0, 1'b0, ce, b, 1'b1, 1'b0, 1'b0);
         end
      end
      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   function automatic logic win_op(input int k, input logic [1:0] m, input int r, input int c);
      logic acc;
      logic v;
      if (m[1]) return img[r][c];
      acc = (m == 2'b00);
      for (int dr = 0; dr < k; dr++)
         for (int dc = 0; dc < k; dc++) begin
            if (r - dr < 0 || c - dc < 0) v = (m == 2'b00);
            else v = img[r-dr][c-dc];
            acc = (m == 2'b00) ? (acc & v) : (acc | v);
         end
      return acc;
   endfunction

   task automatic golden(input logic [1:0] m);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
            exp3[r][c] = win_op(3, m, r, c);
            exp5[r][c] = win_op(5, m, r, c);
         end
   endtask

   task automatic rand_img(input logic [1:0] m);
      int dens;
      dens = (m == 2'b00) ? 90 : ((m == 2'b01) ? 8 : 50);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            img[r][c] = (int'($urandom_range(99)) < dens);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, expected end of run");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t       vt [11];
      logic [1:0] m;
      vt[0]  = '{2'b00, 0, 3, 2, 1'b0, 3, 5, 2, 4, 3, 7, 2, 5};
      vt[1]  = '{2'b01, 0, 3, 2, 1'b1, 3, 5, 2, 4, 3, 7, 2, 5};
      vt[2]  = '{2'b01, 0, 7, 5, 1'b1, 7, 7, 5, 5, 7, 7, 5, 5};
      vt[3]  = '{2'b00, 1, 3, 2, 1'b0, 3, 5, 2, 4, 3, 7, 2, 5};
      vt[4]  = '{2'b01, 1, 3, 2, 1'b1, 3, 5, 2, 4, 3, 7, 2, 5};
      vt[5]  = '{2'b01, 2, 7, 5, 1'b1, 7, 7, 5, 5, 7, 7, 5, 5};
      vt[6]  = '{2'b00, 0, 2, 2, 1'b0, 2, 4, 2, 4, 2, 6, 2, 5};
      vt[7]  = '{2'b01, 0, 0, 0, 1'b1, 0, 2, 0, 2, 0, 4, 0, 4};
      vt[8]  = '{2'b00, 1, 0, 5, 1'b0, 0, 2, 5, 5, 0, 4, 5, 5};
      vt[9]  = '{2'b10, 0, 4, 1, 1'b1, 4, 4, 1, 1, 4, 4, 1, 1};
      vt[10] = '{2'b11, 1, 6, 3, 1'b0, 6, 6, 3, 3, 6, 6, 3, 3};

      for (int i = 0; i < NEXP; i++) exp_tab[i].v = 1'b0;
      rst_n = 1'b0;
      mode  = 2'b00;
      vs_i  = 1'b0;
      hr_i  = 1'b0;
      ce_i  = 1'b0;
      bit_i = 1'b0;
      rst_cnt = 3;
      repeat (6) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      // Directed single-pixel frames with hand-derived result regions.
      for (int i = 0; i < 11; i++) begin
         for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
               img[r][c]  = (c == vt[i].px && r == vt[i].py) ? vt[i].pv : ~vt[i].pv;
               exp3[r][c] = (c >= vt[i].x0 && c <= vt[i].x1 && r >= vt[i].y0 && r <= vt[i].y1)
                            ? vt[i].pv : ~vt[i].pv;
               exp5[r][c] = (c >= vt[i].u0 && c <= vt[i].u1 && r >= vt[i].v0 && r <= vt[i].v1)
                            ? vt[i].pv : ~vt[i].pv;
            end
         drive_frame(vt[i].m, vt[i].gap, -1, 2'b00, -1, 0);
      end

      // Mode change mid-frame only takes effect on the next frame.
      rand_img(2'b00); golden(2'b00);
      drive_frame(2'b00, 0, 3, 2'b01, -1, 0);
      rand_img(2'b01); golden(2'b01);
      drive_frame(2'b01, 0, -1, 2'b01, -1, 0);

      // Bypass with clken gaps: every href cycle is the input bit delayed.
      rand_img(2'b10); golden(2'b10);
      drive_frame(2'b10, 1, -1, 2'b10, -1, 0);

      // Reset held 5 clocks mid-line in row 2: rest of frame blank, next frame normal.
      rand_img(2'b01); golden(2'b01);
      drive_frame(2'b01, 0, -1, 2'b01, 2, 5);
      rand_img(2'b00); golden(2'b00);
      drive_frame(2'b00, 0, -1, 2'b00, -1, 0);

      // Random frames against the window model.
      for (int f = 0; f < 10; f++) begin
         m = 2'($urandom_range(3));
         rand_img(m); golden(m);
         drive_frame(m, int'($urandom_range(2)), -1, m, -1, 0);
      end

      repeat (6) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/morph_filter_nxn.md
Name: morph_filter_nxn

Overview:
- Parametrised binary morphology stage for the frame-difference motion path. Sits between the binarizer and the blob/bounding-box logic.
- Generalises the fixed 5x5 erosion stage: KxK kernel (3 or 5), runtime-selectable erosion/dilation/bypass latched per frame, defined border padding and internal line buffering.
- Streams one bit per clken and preserves the vsync/href/clken framing.

Parameters:
- IMG_HDISP, 640, active pixels per line; sets line-buffer depth.
- IMG_VDISP, 480, active lines per frame; sets row-counter width.
- KSIZE, 5, kernel edge length; legal values are 3 and 5 only, anything else is a compile-time error.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset; synchronous, active-low
- mode  in  2  00 = erosion, 01 = dilation, 10/11 = bypass; sampled at frame start only
- per_frame_vsync  in  1  input frame sync
- per_frame_href  in  1  input line valid
- per_frame_clken  in  1  input pixel strobe
- per_img_Bit  in  1  input binary pixel (1 = foreground)
- post_frame_vsync  out  1  vsync delayed 3 clk
- post_frame_href  out  1  href delayed 3 clk
- post_frame_clken  out  1  clken delayed 3 clk
- post_img_Bit  out  1  filtered pixel; 0 whenever post_frame_href = 0

Behaviour:
- Reset: one clock only; reset is synchronous and active-low (clk, rst_n).
  - While rst_n = 0 at a clk edge: all outputs go to 0; delay lines, column/row counters and window registers clear; active mode becomes erosion; frame_ok clears.
- Counters:
  - col counts clken while href = 1 and resets on href falling edge.
  - row increments on href falling edge (saturating at IMG_VDISP-1) and resets on vsync rising edge.
- Line buffers: KSIZE-1 lines of IMG_HDISP bits, written and shifted only on clken with href = 1.
- Window: the result emitted for input pixel (c, r) uses the KxK window covering cols c-KSIZE+1..c and rows r-KSIZE+1..r. This is bottom-right aligned, with no end-of-frame flush.
- Padding: window positions with col < 0 or row < 0 take the neutral value, 1 for erosion and 0 for dilation. Line-buffer contents from the previous frame are never used.
- Operation:
  - Erosion: AND of all K*K bits.
  - Dilation: OR of all K*K bits.
  - Bypass: the centre-free passthrough of per_img_Bit itself, delayed 3 clk.
- Pipeline: exactly 3 clk from input sample to output, independent of clken gaps.
  - Stage 1: window update.
  - Stage 2: per-row reduction.
  - Stage 3: cross-row reduction.
  - Sync signals use a matching 3-deep shift register that runs every clk, not gated by clken.
- Mode latching: mode is captured into active_mode on the vsync rising edge only. A change mid-frame takes effect from the next frame.
- frame_ok: set on the first vsync rising edge after reset. Until it is set, post_img_Bit = 0 while sync outputs still propagate.
- Simultaneous events:
  - vsync rising edge in the same cycle as an href falling edge: row resets; the vsync reset wins.
  - clken = 1 with href = 0: ignored, no buffer write.

Test Plan:
- Reset: hold rst_n = 0 for 5 clk mid-stream -> all outputs 0 from the first edge with rst_n low; active_mode = erosion after release.
- KSIZE = 3, 8x6 frame, erosion, all ones except 0 at (3,2) -> post_img_Bit = 0 exactly at c in 3..5, r in 2..4; 1 elsewhere, borders included via padding.
- KSIZE = 3, dilation, single 1 at (3,2) -> 1 at c 3..5, r 2..4, else 0. Single 1 at (7,5) alone -> only (7,5) = 1.
- Same stimuli with clken high every other cycle -> post_frame_clken is the input pattern delayed 3 clk; pixel results identical to the contiguous run.
- Mode switched to 01 at row 3 of frame N -> frame N is entirely erosion, frame N+1 is dilation. Mode 10 -> post_img_Bit equals per_img_Bit delayed 3 clk.
- Reset pulsed at row 2 mid-frame -> post_img_Bit = 0 for the remainder of that frame; the next frame matches the golden model. Repeat the erosion case with KSIZE = 5: a single 0 at (2,2) clears c 2..6 and r 2..6, clipped to the frame.
